mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 28 ++
 rtl/sync_ram.sv | 23 ++
 rtl/mem_responder.sv | 131 +++++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MAR/MDR memory responder.
// Holds the FSM state encoding, the I/O address and the optional RAM preload table.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_RELEASE,
        ST_INIT
    } mem_state_t;

    localparam logic [15:0] IO_ADDR  = 16'hFFFF;

    localparam int          INIT_LEN = 8;
    localparam logic [15:0] INIT_TABLE [INIT_LEN] = '{
        16'h1001, 16'h2002, 16'h3003, 16'h4004,
        16'h5005, 16'h6006, 16'h7007, 16'h8008
    };

    // Preload word for RAM index idx; the RAM beyond the table is cleared to zero.
    function automatic logic [15:0] init_word(input logic [15:0] idx);
        logic [2:0] sel;
        sel = idx[2:0];
        return (idx < 16'(INIT_LEN)) ? INIT_TABLE[sel] : 16'h0000;
    endfunction

endpackage

// File: rtl/sync_ram.sv
// Single-port 16-bit RAM: clocked write, registered read.
// Latency: read data 1 cycle after address. No backpressure; one access per cycle.
// Read-during-write returns the old word.
module sync_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 Clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);

    logic [15:0] mem [2**ADDR_BITS];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the CPU MAR/MDR bus: RAM plus switch/hex I/O at 16'hFFFF.
// Latency: R pulses LATENCY+2 cycles after the request is seen; read data valid the cycle after R.
// Backpressure: one request at a time; the CPU holds MEM_OE/MEM_WE until R. MEM_INIT_EN adds a RAM preload.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_From_CPU,
    input  logic [15:0] SW,
    output logic [15:0] Data_To_CPU,
    output logic        R,
    output logic [15:0] HEX_Data,
    output logic        Busy
);

`ifdef MEM_INIT_EN
    localparam mem_state_t RESET_STATE = ST_INIT;
`else
    localparam mem_state_t RESET_STATE = ST_IDLE;
`endif

    mem_state_t             state_q, state_d;
    logic [3:0]             cnt_q;
    logic                   op_wr_q;
    logic [15:0]            addr_q;
    logic [15:0]            data_q;
    logic                   is_io;
    logic                   req;
    logic                   ram_we;
    logic [ADDR_BITS-1:0]   ram_addr;
    logic [15:0]            ram_wdata;
    logic [15:0]            ram_rdata;
`ifdef MEM_INIT_EN
    logic [ADDR_BITS-1:0]   init_cnt_q;
`endif

    assign req   = MEM_OE | MEM_WE;
    assign is_io = (addr_q == IO_ADDR);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req) state_d = ST_WAIT;
            ST_WAIT:    if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP:    state_d = ST_RELEASE;
            ST_RELEASE: if (!req) state_d = ST_IDLE;
`ifdef MEM_INIT_EN
            ST_INIT:    if (init_cnt_q == {ADDR_BITS{1'b1}}) state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    // The RAM reads addr_q continuously, so the word is ready by RESP for any latency.
    always_comb begin
        R         = (state_q == ST_RESP);
        Busy      = (state_q != ST_IDLE);
        ram_addr  = addr_q[ADDR_BITS-1:0];
        ram_wdata = data_q;
        ram_we    = (state_q == ST_RESP) && op_wr_q && !is_io && !Reset;
`ifdef MEM_INIT_EN
        if (state_q == ST_INIT) begin
            ram_addr  = init_cnt_q;
            ram_wdata = init_word(16'(init_cnt_q));
            ram_we    = !Reset;
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q       <= 4'd0;
            op_wr_q     <= 1'b0;
            addr_q      <= 16'h0000;
            data_q      <= 16'h0000;
            Data_To_CPU <= 16'h0000;
            HEX_Data    <= 16'h0000;
`ifdef MEM_INIT_EN
            init_cnt_q  <= '0;
`endif
        end else begin
            if (state_q == ST_IDLE && req) begin
                addr_q  <= ADDR;
                data_q  <= Data_From_CPU;
                op_wr_q <= MEM_WE;
                cnt_q   <= 4'(LATENCY);
            end
            if (state_q == ST_WAIT && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (state_q == ST_RESP) begin
                if (!op_wr_q) begin
                    Data_To_CPU <= is_io ? SW : ram_rdata;
                end else if (is_io) begin
                    HEX_Data <= data_q;
                end
            end
`ifdef MEM_INIT_EN
            if (state_q == ST_INIT) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
`endif
        end
    end

    sync_ram #(
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder with a word-level memory model.
// MEM_INIT_EN, when defined, also exercises the preload phase.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AB    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AB;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        MEM_OE = 1'b0;
    logic        MEM_WE = 1'b0;
    logic [15:0] ADDR = 16'h0;
    logic [15:0] Data_From_CPU = 16'h0;
    logic [15:0] SW = 16'h0;
    logic [15:0] Data_To_CPU;
    logic        R;
    logic [15:0] HEX_Data;
    logic        Busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] mmem  [DEPTH];
    bit          known [DEPTH];
    logic [15:0] exp_data;
    bit          exp_data_known;
    logic [15:0] exp_hex;

    mem_responder #(.ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .MEM_OE        (MEM_OE),
        .MEM_WE        (MEM_WE),
        .ADDR          (ADDR),
        .Data_From_CPU (Data_From_CPU),
        .SW            (SW),
        .Data_To_CPU   (Data_To_CPU),
        .R             (R),
        .HEX_Data      (HEX_Data),
        .Busy          (Busy)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n, input bit probe);
        int busy_n;
        int r_seen;
        int r_at;
        @(negedge Clk);
        Reset = 1'b1; MEM_OE = 1'b0; MEM_WE = 1'b0;
        repeat (n) @(negedge Clk);
        Reset = 1'b0;
        exp_data = 16'h0; exp_data_known = 1'b1; exp_hex = 16'h0;
        chk("rst_data", 32'(Data_To_CPU), 32'h0);
        chk("rst_hex",  32'(HEX_Data),    32'h0);
        chk("rst_r",    32'(R),           32'h0);
`ifdef MEM_INIT_EN
        chk("rst_busy", 32'(Busy), 32'h1);
        if (probe) begin
            MEM_OE = 1'b1; ADDR = 16'h0000;
        end
        busy_n = 0; r_seen = 0;
        while (Busy === 1'b1 && busy_n < DEPTH + 50) begin
            if (R === 1'b1) r_seen++;
            busy_n++;
            @(negedge Clk);
        end
        chk("init_busy_cycles", 32'(busy_n), 32'(DEPTH));
        chk("init_no_r", 32'(r_seen), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            mmem[i]  = init_word(16'(i));
            known[i] = 1'b1;
        end
        if (probe) begin
            r_at = -1;
            for (int i = 1; i <= LAT + 2; i++) begin
                @(negedge Clk);
                if (R === 1'b1 && r_at < 0) r_at = i;
            end
            chk("init_req_r_at", 32'(r_at), 32'(LAT + 2));
            @(negedge Clk);
            exp_data = init_word(16'h0);
            chk("init_read0", 32'(Data_To_CPU), 32'(exp_data));
            MEM_OE = 1'b0;
            repeat (2) @(negedge Clk);
        end
`else
        chk("rst_busy", 32'(Busy), 32'h0);
        if (probe) chk("rst_idle_r", 32'(R), 32'h0);
`endif
    endtask

    task automatic access(input bit we, input bit oe, input logic [15:0] a,
                          input logic [15:0] d, input int hold);
        int         r_at;
        int         r_cnt;
        int         idx;
        bit         io;
        r_at  = -1;
        r_cnt = 0;
        idx   = int'(a) % DEPTH;
        io    = (a == 16'hFFFF);
        @(negedge Clk);
        MEM_WE = we; MEM_OE = oe; ADDR = a; Data_From_CPU = d;
        if (we) begin
            if (io) exp_hex = d;
            else begin
                mmem[idx]  = d;
                known[idx] = 1'b1;
            end
        end else if (io) begin
            exp_data = SW; exp_data_known = 1'b1;
        end else begin
            exp_data = mmem[idx]; exp_data_known = known[idx];
        end
        for (int i = 1; i <= LAT + 3 + hold; i++) begin
            @(negedge Clk);
            if (R === 1'b1) begin
                r_cnt++;
                if (r_at < 0) r_at = i;
            end
            if (i == LAT + 3) begin
                if (exp_data_known) chk("data", 32'(Data_To_CPU), 32'(exp_data));
                chk("hex", 32'(HEX_Data), 32'(exp_hex));
            end
        end
        MEM_WE = 1'b0; MEM_OE = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            if (R === 1'b1) r_cnt++;
        end
        chk("r_at", 32'(r_at), 32'(LAT + 2));
        chk("r_count", 32'(r_cnt), 32'h1);
        chk("idle_busy", 32'(Busy), 32'h0);
    endtask

    initial begin
        int          r_cnt;
        int          op;
        logic [5:0]  hi;
        logic [9:0]  lo;
        logic [15:0] a;
        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0;
            mmem[i]  = 16'h0;
        end

        do_reset(2, 1'b1);

        // RAM round trip
        access(1'b1, 1'b0, 16'h0010, 16'h1234, 0);
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 0);

        // I/O read, I/O write, RAM untouched by I/O write
        SW = 16'hBEEF;
        access(1'b0, 1'b1, 16'hFFFF, 16'h0000, 0);
        access(1'b1, 1'b0, 16'h03FF, 16'h3C3C, 0);
        access(1'b1, 1'b0, 16'hFFFF, 16'h00A5, 0);
        access(1'b0, 1'b1, 16'h03FF, 16'h0000, 0);

        // Write priority, then a request held long after R
        access(1'b1, 1'b1, 16'h0020, 16'h5555, 0);
        access(1'b0, 1'b1, 16'h0020, 16'h0000, 0);
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 5);

        // Reset during WAIT of a write aborts it
        access(1'b1, 1'b0, 16'h0030, 16'h7777, 0);
        @(negedge Clk);
        MEM_WE = 1'b1; ADDR = 16'h0030; Data_From_CPU = 16'h9999;
        r_cnt = 0;
        @(negedge Clk);
        if (R === 1'b1) r_cnt++;
        do_reset(1, 1'b0);
        repeat (LAT + 3) begin
            @(negedge Clk);
            if (R === 1'b1) r_cnt++;
        end
        chk("abort_no_r", 32'(r_cnt), 32'h0);
        access(1'b0, 1'b1, 16'h0030, 16'h0000, 0);

        // Address wrap modulo DEPTH
        access(1'b1, 1'b0, 16'h0405, 16'hCAFE, 0);
        access(1'b0, 1'b1, 16'h0005, 16'h0000, 0);

        // Randomized traffic over a small aliased window plus I/O
        for (int n = 0; n < 40; n++) begin
            SW = 16'($urandom);
            hi = 6'($urandom_range(0, 63));
            lo = 10'h100 + 10'($urandom_range(0, 15));
            a  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : {hi, lo};
            op = int'($urandom_range(0, 2));
            if (op == 1 && (a == 16'hFFFF || known[int'(a) % DEPTH]))
                access(1'b0, 1'b1, a, 16'($urandom), int'($urandom_range(0, 3)));
            else
                access(1'b1, (op == 2), a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
